trap_controller: RTL and testbench

Sequences machine-mode trap entry and `mret` return for the Risco-5 core around the CSR unit. It does four things:
- prioritises pending-and-enabled interrupts against synchronous exceptions;
- stalls the pipeline while it writes mepc/mcause/mtval and updates mstatus through a dedicated CSR trap port;
- issues a single-cycle PC redirect to the mtvec target (direct or vectored) or back to mepc;
- provides the level `interrupt_pending` signal the core uses to gate fetch.

---
 rtl/trap_controller_pkg.sv | 34 +++
 rtl/trap_controller_if.sv | 44 ++++
 rtl/trap_controller_irq_priority_encoder.sv | 36 +++
 rtl/trap_controller.sv | 159 +++++++++++++++
 tb/tb_trap_controller.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_controller_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states,
// exception/interrupt cause codes and the implemented-interrupt mask.
package trap_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SAVE     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_RETURN   = 2'd3
  } state_t;

  localparam logic [4:0] EXC_ILLEGAL   = 5'd2;
  localparam logic [4:0] EXC_EBREAK    = 5'd3;
  localparam logic [4:0] EXC_ECALL     = 5'd11;

  localparam logic [4:0] IRQ_MSI       = 5'd3;
  localparam logic [4:0] IRQ_MTI       = 5'd7;
  localparam logic [4:0] IRQ_MEI       = 5'd11;
  localparam int         IRQ_FAST_BASE = 16;

  // Only MSI/MTI/MEI and the implemented fast lines may ever raise a trap.
  function automatic logic [31:0] irq_valid_mask(input int fast_irqs);
    logic [31:0] mask;
    mask          = '0;
    mask[IRQ_MSI] = 1'b1;
    mask[IRQ_MTI] = 1'b1;
    mask[IRQ_MEI] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < fast_irqs) mask[IRQ_FAST_BASE + i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Core/CSR-side signal bundle of the trap controller; the slave modport is
// the controller itself, the master modport is the core and CSR unit.
interface trap_controller_if;

  logic        mstatus_mie;
  logic [31:0] csr_mie;
  logic [31:0] csr_mip;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        retire;
  logic [31:0] next_pc;
  logic        exc_illegal;
  logic        exc_ecall;
  logic        exc_ebreak;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret;

  logic        stall;
  logic        trap_we;
  logic [31:0] trap_mepc;
  logic [31:0] trap_mcause;
  logic [31:0] trap_mtval;
  logic        mstatus_trap;
  logic        mstatus_mret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        interrupt_pending;

  modport slave (
    input  mstatus_mie, csr_mie, csr_mip, csr_mtvec, csr_mepc, retire, next_pc,
           exc_illegal, exc_ecall, exc_ebreak, exc_pc, exc_tval, mret,
    output stall, trap_we, trap_mepc, trap_mcause, trap_mtval, mstatus_trap,
           mstatus_mret, redirect_valid, redirect_pc, interrupt_pending
  );

  modport master (
    output mstatus_mie, csr_mie, csr_mip, csr_mtvec, csr_mepc, retire, next_pc,
           exc_illegal, exc_ecall, exc_ebreak, exc_pc, exc_tval, mret,
    input  stall, trap_we, trap_mepc, trap_mcause, trap_mtval, mstatus_trap,
           mstatus_mret, redirect_valid, redirect_pc, interrupt_pending
  );

endinterface

// File: rtl/trap_controller_irq_priority_encoder.sv
// Picks the highest-priority pending interrupt:
// MEI > MSI > MTI > fast 16 > 17 > ... > 31.
module irq_priority_encoder
  import trap_controller_pkg::*;
(
  input  logic [31:0] pending,
  output logic        valid,
  output logic [4:0]  code
);

  // Later assignments override earlier ones, so the walk runs from lowest
  // to highest priority.
  always_comb begin
    valid = 1'b0;
    code  = '0;
    for (int i = 31; i >= IRQ_FAST_BASE; i--) begin
      if (pending[i]) begin
        valid = 1'b1;
        code  = 5'(i);
      end
    end
    if (pending[IRQ_MTI]) begin
      valid = 1'b1;
      code  = IRQ_MTI;
    end
    if (pending[IRQ_MSI]) begin
      valid = 1'b1;
      code  = IRQ_MSI;
    end
    if (pending[IRQ_MEI]) begin
      valid = 1'b1;
      code  = IRQ_MEI;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry / mret sequencer: prioritises exceptions and
// interrupts, drives the CSR trap port and issues the PC redirect.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int          FAST_IRQS    = 16,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  trap_controller_if.slave  bus
);

  localparam logic [31:0] VALID_MASK = irq_valid_mask(FAST_IRQS);

  state_t      state;
  state_t      state_next;

  logic [31:0] pending;
  logic        irq_valid;
  logic [4:0]  irq_code;
  logic        irq_req;

  logic        exc_any;
  logic [4:0]  exc_code;
  logic        idle_ok;
  logic        accept_exc;
  logic        accept_mret;
  logic        accept_irq;

  logic [4:0]  cause_code;
  logic        cause_irq;
  logic [31:0] mepc_q;
  logic [31:0] mtval_q;

  logic [31:0] trap_base;
  logic [31:0] trap_target;

  logic        stall;
  logic        trap_we;
  logic [31:0] trap_mepc;
  logic [31:0] trap_mcause;
  logic [31:0] trap_mtval;
  logic        mstatus_trap;
  logic        mstatus_mret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  assign pending = bus.csr_mie & bus.csr_mip & VALID_MASK;

  irq_priority_encoder u_irq_priority_encoder (
    .pending (pending),
    .valid   (irq_valid),
    .code    (irq_code)
  );

  assign irq_req               = bus.mstatus_mie & irq_valid;
  assign bus.interrupt_pending = irq_req;

  // Exceptions beat mret, mret beats interrupts; nothing is accepted
  // outside IDLE or while reset is asserted.
  always_comb begin
    exc_any     = bus.exc_illegal | bus.exc_ecall | bus.exc_ebreak;
    exc_code    = bus.exc_illegal ? EXC_ILLEGAL :
                  bus.exc_ebreak  ? EXC_EBREAK  : EXC_ECALL;
    idle_ok     = (state == ST_IDLE) & ~reset;
    accept_exc  = idle_ok & exc_any;
    accept_mret = idle_ok & ~exc_any & bus.mret;
    accept_irq  = idle_ok & ~exc_any & ~bus.mret & irq_req & bus.retire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cause_code <= '0;
      cause_irq  <= 1'b0;
      mepc_q     <= '0;
      mtval_q    <= '0;
    end else begin
      state <= state_next;
      if (accept_exc) begin
        cause_code <= exc_code;
        cause_irq  <= 1'b0;
        mepc_q     <= bus.exc_pc;
        mtval_q    <= bus.exc_tval;
      end else if (accept_irq) begin
        cause_code <= irq_code;
        cause_irq  <= 1'b1;
        mepc_q     <= bus.next_pc;
        mtval_q    <= '0;
      end
    end
  end

  // Vectored offset applies only to interrupts; mtvec==0 falls back to
  // the reset vector.
  always_comb begin
    trap_base   = (bus.csr_mtvec == 32'h0) ? RESET_VECTOR
                                            : {bus.csr_mtvec[31:2], 2'b00};
    trap_target = trap_base;
    if (bus.csr_mtvec[0] && cause_irq) begin
      trap_target = trap_base + {25'b0, cause_code, 2'b00};
    end
  end

  always_comb begin
    state_next     = state;
    stall          = 1'b0;
    trap_we        = 1'b0;
    trap_mepc      = '0;
    trap_mcause    = '0;
    trap_mtval     = '0;
    mstatus_trap   = 1'b0;
    mstatus_mret   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      ST_IDLE: begin
        stall = accept_exc | accept_mret | accept_irq;
        if (accept_exc || accept_irq) state_next = ST_SAVE;
        else if (accept_mret)         state_next = ST_RETURN;
      end
      ST_SAVE: begin
        stall        = 1'b1;
        trap_we      = 1'b1;
        mstatus_trap = 1'b1;
        trap_mepc    = mepc_q;
        trap_mcause  = {cause_irq, 26'b0, cause_code};
        trap_mtval   = mtval_q;
        state_next   = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = trap_target;
        state_next     = ST_IDLE;
      end
      ST_RETURN: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        mstatus_mret   = 1'b1;
        redirect_pc    = {bus.csr_mepc[31:2], 2'b00};
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.stall          = stall;
  assign bus.trap_we        = trap_we;
  assign bus.trap_mepc      = trap_mepc;
  assign bus.trap_mcause    = trap_mcause;
  assign bus.trap_mtval     = trap_mtval;
  assign bus.mstatus_trap   = mstatus_trap;
  assign bus.mstatus_mret   = mstatus_mret;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed scenarios plus randomized traffic,
// all checked every cycle against a schedule-based reference model.
module tb_trap_controller;

  localparam logic [31:0] RV_A = 32'h0000_1000;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_pass   = 0;

  trap_controller_if ifa ();
  trap_controller_if ifb ();

  trap_controller #(.FAST_IRQS(16), .RESET_VECTOR(RV_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  trap_controller #(.FAST_IRQS(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  assign ifb.mstatus_mie = ifa.mstatus_mie;
  assign ifb.csr_mie     = ifa.csr_mie;
  assign ifb.csr_mip     = ifa.csr_mip;
  assign ifb.csr_mtvec   = ifa.csr_mtvec;
  assign ifb.csr_mepc    = ifa.csr_mepc;
  assign ifb.retire      = ifa.retire;
  assign ifb.next_pc     = ifa.next_pc;
  assign ifb.exc_illegal = ifa.exc_illegal;
  assign ifb.exc_ecall   = ifa.exc_ecall;
  assign ifb.exc_ebreak  = ifa.exc_ebreak;
  assign ifb.exc_pc      = ifa.exc_pc;
  assign ifb.exc_tval    = ifa.exc_tval;
  assign ifb.mret        = ifa.mret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic logic [31:0] fast_mask(input int fast);
    logic [31:0] m;
    m = 32'h0000_0888;
    for (int i = 0; i < fast; i++) m[16 + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [4:0] pick_code(input logic [31:0] p);
    int order[19];
    order[0] = 11; order[1] = 3; order[2] = 7;
    for (int i = 0; i < 16; i++) order[3 + i] = 16 + i;
    for (int i = 0; i < 19; i++) if (p[order[i]]) return 5'(order[i]);
    return 5'd0;
  endfunction

  // Reference model: each accepted event schedules its pulses at fixed
  // offsets from the accept cycle; the controller is busy until free_at.
  typedef enum int {K_NONE, K_TRAP, K_MRET} kind_t;
  int          cyc      = 0;
  int          free_at  = 0;
  int          acc      = -10;
  kind_t       kind     = K_NONE;
  logic [4:0]  m_code;
  logic        m_irq;
  logic [31:0] m_mepc;
  logic [31:0] m_mtval;
  bit          live     = 0;

  always @(negedge clk) begin
    logic        exc, irq_a, irq_b, idle, accept, exp_we, exp_redir;
    logic [31:0] target;
    exc   = ifa.exc_illegal | ifa.exc_ecall | ifa.exc_ebreak;
    irq_a = ifa.mstatus_mie && ((ifa.csr_mie & ifa.csr_mip & fast_mask(16)) != 0);
    irq_b = ifa.mstatus_mie && ((ifa.csr_mie & ifa.csr_mip & fast_mask(4)) != 0);
    idle  = cyc >= free_at;
    accept = !reset && idle && (exc || ifa.mret || (irq_a && ifa.retire));
    if (live) begin
      exp_we    = (kind == K_TRAP) && (cyc == acc + 1);
      exp_redir = ((kind == K_TRAP) && (cyc == acc + 2)) ||
                  ((kind == K_MRET) && (cyc == acc + 1));
      check_output("interrupt_pending_a", 32'(ifa.interrupt_pending), 32'(irq_a));
      check_output("interrupt_pending_b", 32'(ifb.interrupt_pending), 32'(irq_b));
      check_output("stall", 32'(ifa.stall), 32'(!idle || accept));
      check_output("trap_we", 32'(ifa.trap_we), 32'(exp_we));
      check_output("mstatus_trap", 32'(ifa.mstatus_trap), 32'(exp_we));
      check_output("mstatus_mret", 32'(ifa.mstatus_mret),
                   32'((kind == K_MRET) && (cyc == acc + 1)));
      check_output("redirect_valid", 32'(ifa.redirect_valid), 32'(exp_redir));
      if (exp_we) begin
        check_output("trap_mepc", ifa.trap_mepc, m_mepc);
        check_output("trap_mcause", ifa.trap_mcause, {m_irq, 26'b0, m_code});
        check_output("trap_mtval", ifa.trap_mtval, m_mtval);
      end
      if (exp_redir) begin
        if (kind == K_MRET) begin
          target = ifa.csr_mepc & ~32'h3;
        end else begin
          target = (ifa.csr_mtvec == 0) ? RV_A : (ifa.csr_mtvec & ~32'h3);
          if (ifa.csr_mtvec[0] && m_irq) target = target + 32'(m_code) * 4;
        end
        check_output("redirect_pc", ifa.redirect_pc, target);
      end
    end
    if (reset) begin
      free_at = cyc + 1;
      kind    = K_NONE;
      live    = 1;
    end else if (accept) begin
      acc = cyc;
      if (exc) begin
        kind    = K_TRAP;
        m_irq   = 1'b0;
        m_code  = ifa.exc_illegal ? 5'd2 : ifa.exc_ebreak ? 5'd3 : 5'd11;
        m_mepc  = ifa.exc_pc;
        m_mtval = ifa.exc_tval;
        free_at = cyc + 3;
      end else if (ifa.mret) begin
        kind    = K_MRET;
        free_at = cyc + 2;
      end else begin
        kind    = K_TRAP;
        m_irq   = 1'b1;
        m_code  = pick_code(ifa.csr_mie & ifa.csr_mip & fast_mask(16));
        m_mepc  = ifa.next_pc;
        m_mtval = 32'h0;
        free_at = cyc + 3;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    reset           = 1'b0;
    ifa.mstatus_mie = 1'b0;
    ifa.csr_mie     = '0;
    ifa.csr_mip     = '0;
    ifa.csr_mtvec   = 32'h100;
    ifa.csr_mepc    = '0;
    ifa.retire      = 1'b0;
    ifa.next_pc     = '0;
    ifa.exc_illegal = 1'b0;
    ifa.exc_ecall   = 1'b0;
    ifa.exc_ebreak  = 1'b0;
    ifa.exc_pc      = '0;
    ifa.exc_tval    = '0;
    ifa.mret        = 1'b0;
  endtask

  task automatic settle();
    quiet();
    repeat (4) step();
  endtask

  task automatic apply_stimulus();
    logic [1:0] sel;
    reset           = ($urandom_range(0, 63) == 0);
    ifa.mstatus_mie = ($urandom_range(0, 3) != 0);
    ifa.csr_mie     = $urandom;
    ifa.csr_mip     = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
    sel             = 2'($urandom_range(0, 3));
    ifa.csr_mtvec   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h100 :
                      (sel == 2) ? 32'h201 : $urandom;
    ifa.csr_mepc    = $urandom;
    ifa.retire      = $urandom_range(0, 1) == 1;
    ifa.next_pc     = $urandom;
    ifa.exc_illegal = ($urandom_range(0, 11) == 0);
    ifa.exc_ecall   = ($urandom_range(0, 11) == 0);
    ifa.exc_ebreak  = ($urandom_range(0, 11) == 0);
    ifa.exc_pc      = $urandom;
    ifa.exc_tval    = $urandom;
    ifa.mret        = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    sample();
    check_output("reset_stall", 32'(ifa.stall), 32'h0);
    check_output("reset_trap_we", 32'(ifa.trap_we), 32'h0);
    check_output("reset_redirect", 32'(ifa.redirect_valid), 32'h0);
    settle();

    // Direct-mode timer interrupt.
    ifa.csr_mtvec = 32'h100; ifa.csr_mie = 32'h80; ifa.csr_mip = 32'h80;
    ifa.mstatus_mie = 1'b1; ifa.retire = 1'b1; ifa.next_pc = 32'h40;
    sample();
    check_output("mti_stall_t0", 32'(ifa.stall), 32'h1);
    step(); ifa.retire = 1'b0; ifa.csr_mip = 32'h0;
    sample();
    check_output("mti_trap_we", 32'(ifa.trap_we), 32'h1);
    check_output("mti_mepc", ifa.trap_mepc, 32'h40);
    check_output("mti_mcause", ifa.trap_mcause, 32'h8000_0007);
    check_output("mti_mtval", ifa.trap_mtval, 32'h0);
    check_output("mti_mstatus_trap", 32'(ifa.mstatus_trap), 32'h1);
    step(); sample();
    check_output("mti_redirect_pc", ifa.redirect_pc, 32'h100);
    step(); sample();
    check_output("mti_stall_t3", 32'(ifa.stall), 32'h0);
    settle();

    // Vectored mode, MEI beats MSI.
    ifa.csr_mtvec = 32'h201; ifa.csr_mie = 32'h808; ifa.csr_mip = 32'h808;
    ifa.mstatus_mie = 1'b1; ifa.retire = 1'b1; ifa.next_pc = 32'h60;
    step(); ifa.retire = 1'b0;
    sample();
    check_output("vec_mcause", ifa.trap_mcause, 32'h8000_000B);
    step(); sample();
    check_output("vec_redirect_pc", ifa.redirect_pc, 32'h22C);
    settle();

    // Illegal instruction alongside a pending MEI.
    ifa.csr_mtvec = 32'h201; ifa.csr_mie = 32'h800; ifa.csr_mip = 32'h800;
    ifa.mstatus_mie = 1'b1; ifa.retire = 1'b1;
    ifa.exc_illegal = 1'b1; ifa.exc_pc = 32'h80; ifa.exc_tval = 32'hFFFF_FFFF;
    step(); ifa.exc_illegal = 1'b0; ifa.retire = 1'b0; ifa.csr_mip = 32'h0;
    sample();
    check_output("ill_mcause", ifa.trap_mcause, 32'h2);
    check_output("ill_mepc", ifa.trap_mepc, 32'h80);
    check_output("ill_mtval", ifa.trap_mtval, 32'hFFFF_FFFF);
    step(); sample();
    check_output("ill_redirect_pc", ifa.redirect_pc, 32'h200);
    settle();

    // mret return.
    ifa.csr_mepc = 32'h47; ifa.mret = 1'b1;
    sample();
    check_output("mret_stall_t0", 32'(ifa.stall), 32'h1);
    step(); ifa.mret = 1'b0;
    sample();
    check_output("mret_redirect_valid", 32'(ifa.redirect_valid), 32'h1);
    check_output("mret_redirect_pc", ifa.redirect_pc, 32'h44);
    check_output("mret_mstatus_mret", 32'(ifa.mstatus_mret), 32'h1);
    step(); sample();
    check_output("mret_stall_t2", 32'(ifa.stall), 32'h0);
    settle();

    // Reset while in SAVE, then a masked-off pending interrupt.
    ifa.csr_mie = 32'h80; ifa.csr_mip = 32'h80; ifa.mstatus_mie = 1'b1;
    ifa.retire = 1'b1;
    step(); reset = 1'b1; ifa.retire = 1'b0; ifa.csr_mip = 32'h0;
    step(); reset = 1'b0;
    sample();
    check_output("rst_save_redirect", 32'(ifa.redirect_valid), 32'h0);
    check_output("rst_save_stall", 32'(ifa.stall), 32'h0);
    check_output("rst_save_trap_we", 32'(ifa.trap_we), 32'h0);
    ifa.mstatus_mie = 1'b0; ifa.csr_mip = 32'h80; ifa.retire = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); sample();
      check_output("mie0_no_trap", 32'(ifa.stall | ifa.trap_we), 32'h0);
    end
    settle();

    // Fast interrupt 20 with 16 and with 4 fast lines.
    ifa.csr_mie = 32'h0010_0000; ifa.csr_mip = 32'h0010_0000;
    ifa.mstatus_mie = 1'b1; ifa.retire = 1'b1; ifa.next_pc = 32'h90;
    sample();
    check_output("fast20_pending_a", 32'(ifa.interrupt_pending), 32'h1);
    check_output("fast20_pending_b", 32'(ifb.interrupt_pending), 32'h0);
    step(); ifa.retire = 1'b0;
    sample();
    check_output("fast20_mcause", ifa.trap_mcause, 32'h8000_0014);
    settle();

    for (int i = 0; i < 3000; i++) begin
      apply_stimulus();
      step();
    end
    quiet();
    repeat (4) step();

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
